// File: rtl/fetch_queue_pkg.sv
// Shared widths and the fetch-queue entry layout for fetch_queue and fetch_btb.
package fetch_queue_pkg;

  localparam int XLEN          = 64;
  localparam int INSTR_W       = 32;
  localparam int COMMIT_INFO_W = 161;

  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic [XLEN-1:0]    pre_pc;
    logic [INSTR_W-1:0] instr;
    logic               filled;
  } fq_entry_t;

endpackage

// File: rtl/fetch_btb.sv
// Direct-mapped branch target buffer: combinational lookup, update written at the clock edge
// so a same-cycle lookup still sees the previous contents.
module fetch_btb
  import fetch_queue_pkg::*;
#(
  parameter int unsigned BTB_ENTRIES = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] lookup_pc,
  output logic            hit,
  output logic [XLEN-1:0] target,
  input  logic            upd_valid,
  input  logic [XLEN-1:0] upd_pc,
  input  logic [XLEN-1:0] upd_target
);

  localparam int unsigned IDX_W = $clog2(BTB_ENTRIES);
  localparam int unsigned TAG_W = XLEN - IDX_W - 2;

  logic [BTB_ENTRIES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]       tag_q    [BTB_ENTRIES];
  logic [TAG_W-1:0]       tag_d    [BTB_ENTRIES];
  logic [XLEN-1:0]        target_q [BTB_ENTRIES];
  logic [XLEN-1:0]        target_d [BTB_ENTRIES];

  logic [IDX_W-1:0] lookup_idx, upd_idx;
  logic [TAG_W-1:0] lookup_tag, upd_tag;
  logic             unused_low_bits;

  // Instructions are word aligned, so pc[1:0] carries no information.
  assign lookup_idx      = lookup_pc[IDX_W+1:2];
  assign lookup_tag      = lookup_pc[XLEN-1:IDX_W+2];
  assign upd_idx         = upd_pc[IDX_W+1:2];
  assign upd_tag         = upd_pc[XLEN-1:IDX_W+2];
  assign unused_low_bits = ^{lookup_pc[1:0], upd_pc[1:0]};

  assign hit    = valid_q[lookup_idx] && (tag_q[lookup_idx] == lookup_tag);
  assign target = target_q[lookup_idx];

  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    if (upd_valid) begin
      valid_d[upd_idx]  = 1'b1;
      tag_d[upd_idx]    = upd_tag;
      target_d[upd_idx] = upd_target;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) valid_q <= '0;
    else     valid_q <= valid_d;
  end

  always_ff @(posedge clk) begin
    tag_q    <= tag_d;
    target_q <= target_d;
  end

endmodule

// File: rtl/fetch_queue.sv
// In-order instruction fetch queue with redirect flush and response dropping.
// Optional BTB next-pc prediction is compiled in when FETCH_BTB_EN is defined.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int unsigned     FQ_DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC    = 64'h8000_0000,
  parameter int unsigned     BTB_ENTRIES = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     imem_req_valid,
  input  logic                     imem_req_ready,
  output logic [XLEN-1:0]          imem_req_addr,
  input  logic                     imem_resp_valid,
  input  logic [INSTR_W-1:0]       imem_resp_data,
  input  logic                     redirect_valid,
  input  logic [XLEN-1:0]          redirect_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [INSTR_W-1:0]       fetch_o_instr,
  output logic [XLEN-1:0]          fetch_o_pc,
  output logic [XLEN-1:0]          fetch_o_pre_pc,
  output logic [COMMIT_INFO_W-1:0] fetch_o_commit_info,
  input  logic                     btb_upd_valid,
  input  logic [XLEN-1:0]          btb_upd_pc,
  input  logic [XLEN-1:0]          btb_upd_target
);

  localparam int unsigned PTR_W = $clog2(FQ_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [CNT_W-1:0] cnt_t;

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d, seq_pc, next_pc;
  ptr_t            head_q, head_d, tail_q, tail_d, fill_q, fill_d;
  cnt_t            count_q, count_d, pending_q, pending_d, drop_q, drop_d;
  cnt_t            inflight;
  logic [CNT_W:0]  budget;
  fq_entry_t       entries_q [FQ_DEPTH];
  fq_entry_t       entries_d [FQ_DEPTH];
  fq_entry_t       head_entry;
  logic            req_fire, pop_fire, fill_fire, drop_fire;

  assign seq_pc = fetch_pc_q + 64'd4;

`ifdef FETCH_BTB_EN
  logic            btb_hit;
  logic [XLEN-1:0] btb_target;

  fetch_btb #(
    .BTB_ENTRIES(BTB_ENTRIES)
  ) u_btb (
    .clk       (clk),
    .rst       (rst),
    .lookup_pc (fetch_pc_q),
    .hit       (btb_hit),
    .target    (btb_target),
    .upd_valid (btb_upd_valid),
    .upd_pc    (btb_upd_pc),
    .upd_target(btb_upd_target)
  );

  assign next_pc = btb_hit ? btb_target : seq_pc;
`else
  logic unused_btb;
  assign unused_btb = ^{btb_upd_valid, btb_upd_pc, btb_upd_target, 32'(BTB_ENTRIES)};
  assign next_pc    = seq_pc;
`endif

  // Dropped responses still owe a slot: they are counted against the depth
  // until they return so the queue never has more requests in flight than entries.
  assign budget         = {1'b0, count_q} + {1'b0, drop_q};
  assign imem_req_valid = !rst && !redirect_valid && (budget < (CNT_W+1)'(FQ_DEPTH));
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign head_entry = entries_q[head_q];
  assign out_valid  = (count_q != '0) && head_entry.filled;
  assign pop_fire   = out_valid && out_ready && !redirect_valid;
  assign drop_fire  = imem_resp_valid && !redirect_valid && (drop_q != '0);
  assign fill_fire  = imem_resp_valid && !redirect_valid && (drop_q == '0) && (pending_q != '0);
  assign inflight   = pending_q + drop_q;

  assign fetch_o_instr       = out_valid ? head_entry.instr  : '0;
  assign fetch_o_pc          = out_valid ? head_entry.pc     : '0;
  assign fetch_o_pre_pc      = out_valid ? head_entry.pre_pc : '0;
  assign fetch_o_commit_info = {out_valid, fetch_o_instr, fetch_o_pre_pc, fetch_o_pc};

  // NOTE: every _d gets its default first, so no path through the block leaves one unassigned (no latch).
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    head_d     = head_q;
    tail_d     = tail_q;
    fill_d     = fill_q;
    count_d    = count_q;
    pending_d  = pending_q;
    drop_d     = drop_q;
    entries_d  = entries_q;

    if (redirect_valid) begin
      fetch_pc_d = redirect_pc;
      head_d     = '0;
      tail_d     = '0;
      fill_d     = '0;
      count_d    = '0;
      pending_d  = '0;
      // A response arriving this cycle answers one in-flight request and is itself discarded.
      drop_d     = (imem_resp_valid && (inflight != '0)) ? inflight - cnt_t'(1) : inflight;
    end else begin
      if (req_fire) begin
        entries_d[tail_q] = '{pc: fetch_pc_q, pre_pc: next_pc, instr: '0, filled: 1'b0};
        tail_d            = tail_q + ptr_t'(1);
        fetch_pc_d        = next_pc;
      end
      if (fill_fire) begin
        entries_d[fill_q].instr  = imem_resp_data;
        entries_d[fill_q].filled = 1'b1;
        fill_d                   = fill_q + ptr_t'(1);
      end
      if (drop_fire) drop_d = drop_q - cnt_t'(1);
      if (pop_fire)  head_d = head_q + ptr_t'(1);
      count_d   = count_q + cnt_t'(req_fire) - cnt_t'(pop_fire);
      pending_d = pending_q + cnt_t'(req_fire) - cnt_t'(fill_fire);
    end
  end

  // NOTE: non-blocking assignments for all state so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      head_q     <= '0;
      tail_q     <= '0;
      fill_q     <= '0;
      count_q    <= '0;
      pending_q  <= '0;
      drop_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      fill_q     <= fill_d;
      count_q    <= count_d;
      pending_q  <= pending_d;
      drop_q     <= drop_d;
    end
  end

  // NOTE: entry storage is not reset; an entry is only read while count_q says it is allocated.
  always_ff @(posedge clk) begin
    entries_q <= entries_d;
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: a memory model pushes expected entries on request accept,
// an output monitor pops and compares on each out_valid/out_ready handshake.
module tb_fetch_queue;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         imem_req_valid;
  logic         imem_req_ready = 1'b0;
  logic [63:0]  imem_req_addr;
  logic         imem_resp_valid = 1'b0;
  logic [31:0]  imem_resp_data = '0;
  logic         redirect_valid = 1'b0;
  logic [63:0]  redirect_pc = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [31:0]  fetch_o_instr;
  logic [63:0]  fetch_o_pc;
  logic [63:0]  fetch_o_pre_pc;
  logic [160:0] fetch_o_commit_info;
  logic         btb_upd_valid = 1'b0;
  logic [63:0]  btb_upd_pc = '0;
  logic [63:0]  btb_upd_target = '0;

  fetch_queue dut (
    .clk                (clk),
    .rst                (rst),
    .imem_req_valid     (imem_req_valid),
    .imem_req_ready     (imem_req_ready),
    .imem_req_addr      (imem_req_addr),
    .imem_resp_valid    (imem_resp_valid),
    .imem_resp_data     (imem_resp_data),
    .redirect_valid     (redirect_valid),
    .redirect_pc        (redirect_pc),
    .out_valid          (out_valid),
    .out_ready          (out_ready),
    .fetch_o_instr      (fetch_o_instr),
    .fetch_o_pc         (fetch_o_pc),
    .fetch_o_pre_pc     (fetch_o_pre_pc),
    .fetch_o_commit_info(fetch_o_commit_info),
    .btb_upd_valid      (btb_upd_valid),
    .btb_upd_pc         (btb_upd_pc),
    .btb_upd_target     (btb_upd_target)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] pc;
    logic [63:0] pre_pc;
    logic [31:0] instr;
  } exp_t;

  exp_t        sb[$];
  logic [63:0] mem_q[$];
  logic [63:0] acc_log[$];
  logic [63:0] pop_pc_log[$];
  logic [63:0] pop_pre_log[$];
  logic [63:0] exp_next_addr = 64'h8000_0000;
  logic        mem_hold = 1'b0;
  int          accept_cnt = 0;
  int          compared = 0;
  int          mismatched = 0;

`ifdef FETCH_BTB_EN
  localparam logic [63:0] BTB_PC  = 64'h8000_0010;
  localparam logic [63:0] BTB_TGT = 64'h8000_0100;
  logic btb_trained = 1'b0;
`endif

  task automatic check(input string name, input logic [160:0] act, input logic [160:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] instr_of(input logic [63:0] a);
    return a[31:0] ^ 32'hC0DE_0013;
  endfunction

  function automatic logic [63:0] exp_pre_of(input logic [63:0] a);
`ifdef FETCH_BTB_EN
    if (btb_trained && a == BTB_PC) return BTB_TGT;
`endif
    return a + 64'd4;
  endfunction

  // Memory model: accepts at the negedge sample, answers in order one cycle later.
  initial begin
    logic [63:0] a;
    logic [63:0] p;
    forever begin
      @(negedge clk);
      if (!rst && imem_req_valid && imem_req_ready) begin
        a = imem_req_addr;
        accept_cnt++;
        acc_log.push_back(a);
        check("req_addr", a, exp_next_addr);
        p = exp_pre_of(a);
        sb.push_back('{pc: a, pre_pc: p, instr: instr_of(a)});
        exp_next_addr = p;
        mem_q.push_back(a);
      end
      @(posedge clk);
      #2;
      if (!mem_hold && mem_q.size() > 0) begin
        imem_resp_valid = 1'b1;
        imem_resp_data  = instr_of(mem_q.pop_front());
      end else begin
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
      end
    end
  end

  // Output monitor.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && !redirect_valid && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("pop_without_expected_entry", 161'(out_valid), 161'd0);
        end else begin
          e = sb.pop_front();
          check("out_pc", fetch_o_pc, e.pc);
          check("out_pre_pc", fetch_o_pre_pc, e.pre_pc);
          check("out_instr", fetch_o_instr, e.instr);
          check("commit_info", fetch_o_commit_info, {1'b1, e.instr, e.pre_pc, e.pc});
          pop_pc_log.push_back(fetch_o_pc);
          pop_pre_log.push_back(fetch_o_pre_pc);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_redirect(input logic [63:0] tgt);
    redirect_valid = 1'b1;
    redirect_pc    = tgt;
    sb.delete();
    acc_log.delete();
    pop_pc_log.delete();
    pop_pre_log.delete();
    exp_next_addr  = tgt;
    next_cycle();
    redirect_valid = 1'b0;
  endtask

  task automatic check_first(input string name, input logic [63:0] q[$], input int idx,
                             input logic [63:0] exp);
    if (q.size() > idx) check(name, q[idx], exp);
    else check(name, 161'(q.size()), 161'(idx + 1));
  endtask

  initial begin
    int cnt0;
    // Reset state
    #1 rst = 1'b1;
    #2;
    check("rst_req_valid", imem_req_valid, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_commit_info", fetch_o_commit_info, 0);
    check("rst_req_addr", imem_req_addr, 64'h8000_0000);
    imem_req_ready = 1'b1;
    out_ready      = 1'b1;
    next_cycle();
    next_cycle();
    rst = 1'b0;

    // Two requests, then the memory stalls for three cycles on 0x80000008
    @(negedge clk);
    check("first_req_valid", imem_req_valid, 1);
    next_cycle();
    next_cycle();
    imem_req_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_req_valid", imem_req_valid, 1);
      check("stall_req_addr", imem_req_addr, 64'h8000_0008);
      next_cycle();
    end
    imem_req_ready = 1'b1;
    repeat (12) next_cycle();
    check_first("stream_first_pc", pop_pc_log, 0, 64'h8000_0000);
    check_first("stream_first_pre_pc", pop_pre_log, 0, 64'h8000_0004);
    check_first("stream_third_pc", pop_pc_log, 2, 64'h8000_0008);

    // Drain, hold two responses, then redirect while they are outstanding
    imem_req_ready = 1'b0;
    repeat (4) next_cycle();
    mem_hold       = 1'b1;
    imem_req_ready = 1'b1;
    cnt0 = accept_cnt;
    next_cycle();
    next_cycle();
    check("held_requests", 161'(accept_cnt - cnt0), 161'd2);
    mem_hold = 1'b0;
    do_redirect(64'h8000_1000);
    @(negedge clk);
    check("out_valid_after_redirect", out_valid, 0);
    next_cycle();
    repeat (6) next_cycle();
    check_first("redirect_first_pc", pop_pc_log, 0, 64'h8000_1000);
    check_first("redirect_first_pre_pc", pop_pre_log, 0, 64'h8000_1004);

    // 64-bit wrap of the sequential pc
    do_redirect(64'hFFFF_FFFF_FFFF_FFFC);
    repeat (6) next_cycle();
    check_first("wrap_pc", pop_pc_log, 0, 64'hFFFF_FFFF_FFFF_FFFC);
    check_first("wrap_pre_pc", pop_pre_log, 0, 64'h0);
    check_first("wrap_next_addr", acc_log, 1, 64'h0);

`ifdef FETCH_BTB_EN
    // Train a taken branch, then fetch it
    btb_upd_valid  = 1'b1;
    btb_upd_pc     = BTB_PC;
    btb_upd_target = BTB_TGT;
    btb_trained    = 1'b1;
    next_cycle();
    btb_upd_valid = 1'b0;
    do_redirect(BTB_PC);
    repeat (6) next_cycle();
    check_first("btb_pc", pop_pc_log, 0, BTB_PC);
    check_first("btb_pre_pc", pop_pre_log, 0, BTB_TGT);
    check_first("btb_next_addr", acc_log, 1, BTB_TGT);
`endif

    // Consumer stalled: the queue fills to its depth and stops requesting
    out_ready = 1'b0;
    cnt0 = accept_cnt;
    do_redirect(64'h8000_0200);
    repeat (10) next_cycle();
    @(negedge clk);
    check("full_request_count", 161'(accept_cnt - cnt0), 161'd4);
    check("full_req_valid", imem_req_valid, 0);
    check("full_out_valid", out_valid, 1);
    next_cycle();
    out_ready = 1'b1;
    next_cycle();
    out_ready = 1'b0;
    cnt0 = accept_cnt;
    repeat (6) next_cycle();
    @(negedge clk);
    check("refill_request_count", 161'(accept_cnt - cnt0), 161'd1);
    check("refill_req_valid", imem_req_valid, 0);
    check_first("full_first_pc", pop_pc_log, 0, 64'h8000_0200);

    // Drain everything
    next_cycle();
    imem_req_ready = 1'b0;
    out_ready      = 1'b1;
    repeat (8) next_cycle();
    check("drained_scoreboard", 161'(sb.size()), 161'd0);
    check("drained_out_valid", out_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter FQ_DEPTH, default 4, queue entries; power of two, at least 2.
REQ-002 SHALL have parameter RESET_PC, default 64'h8000_0000, first fetch address.
REQ-003 SHALL have parameter BTB_ENTRIES, default 16, BTB size; power of two; used only under FETCH_BTB_EN.
REQ-004 SHALL have port clk  input  1  sole clock; all state on its rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have ports imem_req_valid output 1, imem_req_ready input 1, imem_req_addr output 64: instruction-read request.
REQ-007 SHALL have ports imem_resp_valid input 1, imem_resp_data input 32: in-order read response, no backpressure.
REQ-008 SHALL have ports redirect_valid input 1, redirect_pc input 64: flush and restart.
REQ-009 SHALL have ports out_valid output 1, out_ready input 1: downstream handshake.
REQ-010 SHALL have ports fetch_o_instr output 32, fetch_o_pc output 64, fetch_o_pre_pc output 64: head entry.
REQ-011 SHALL have port fetch_o_commit_info output 161 = {out_valid, fetch_o_instr, fetch_o_pre_pc, fetch_o_pc}.
REQ-012 SHALL have ports btb_upd_valid input 1, btb_upd_pc input 64, btb_upd_target input 64: taken-branch training; always present.

Function
REQ-013 SHALL keep a fetch PC register; imem_req_addr = fetch PC.
REQ-014 SHALL assert imem_req_valid when (allocated entries + drop_cnt) < FQ_DEPTH and redirect_valid is low.
REQ-015 SHALL hold imem_req_addr stable while imem_req_valid is high and imem_req_ready is low.
REQ-016 On request accept, SHALL allocate the tail entry with pc and pre_pc, mark it unfilled, and load fetch PC with pre_pc.
REQ-017 pre_pc SHALL be pc + 4, 64-bit, wrapping modulo 2^64, unless REQ-029 applies.
REQ-018 A response with drop_cnt = 0 SHALL fill the oldest unfilled entry; a response with drop_cnt > 0 SHALL be discarded and decrement drop_cnt.
REQ-019 out_valid SHALL be high iff the head entry is filled; a response in cycle N SHALL be visible at outputs in cycle N+1 at the earliest.
REQ-020 A pop SHALL occur when out_valid && out_ready; simultaneous allocate, fill and pop in one cycle SHALL all take effect.
REQ-021 Head and tail pointers SHALL wrap modulo FQ_DEPTH; full and empty SHALL be distinguished by an occupancy count.
REQ-022 On redirect_valid, SHALL flush all entries, set drop_cnt = in-flight unanswered requests (excluding a response in the same cycle), load fetch PC with redirect_pc, and issue no request that cycle.
REQ-023 Redirect SHALL take precedence over pop, fill and allocate in the same cycle; out_valid SHALL be 0 the next cycle.
REQ-024 A response arriving in a redirect cycle SHALL be discarded.

Reset
REQ-025 On rst, asynchronously: fetch PC = RESET_PC; occupancy, pointers and drop_cnt = 0; imem_req_valid = 0; out_valid = 0; fetch_o_* and commit_info = 0; BTB valid bits = 0.
REQ-026 Reset during outstanding requests SHALL abandon them; responses arriving after deassertion are the memory system's responsibility and SHALL NOT be expected.
REQ-027 Requests SHALL start the first cycle after rst deasserts.

Configuration
REQ-028 Macro FETCH_BTB_EN SHALL enable a direct-mapped BTB of BTB_ENTRIES, indexed by pc[log2(BTB_ENTRIES)+1:2], tagged with the remaining upper pc bits.
REQ-029 With FETCH_BTB_EN, a tag hit at request SHALL set pre_pc = stored target; btb_upd_valid SHALL write the entry the next cycle; a same-cycle lookup SHALL see the old entry.
REQ-030 Without FETCH_BTB_EN, pre_pc SHALL always be pc + 4 and the btb_upd_* ports SHALL be ignored.

Structure
REQ-031 A shared package SHALL hold XLEN = 64, INSTR_W = 32, COMMIT_INFO_W = 161, and the queue-entry typedef (pc, pre_pc, instr, filled).
REQ-032 The BTB SHALL be a sub-module, fetch_btb, instantiated only under FETCH_BTB_EN.

Verification
REQ-033 Reset release, memory always ready, 1-cycle responses, out_ready = 1 -> pcs 0x80000000, 0x80000004, ... each with pre_pc = pc + 4.
REQ-034 out_ready = 0 with FQ_DEPTH = 4 -> exactly 4 requests issued, then imem_req_valid = 0; one pop -> exactly one new request.
REQ-035 imem_req_ready low 3 cycles -> imem_req_addr held at 0x80000008 throughout.
REQ-036 Redirect to 0x80001000 with 2 responses outstanding -> those 2 responses dropped; next out_valid entry has pc 0x80001000.
REQ-037 Fetch PC 0xFFFF_FFFF_FFFF_FFFC -> pre_pc = 0, next request address 0.
REQ-038 With FETCH_BTB_EN, train 0x80000010 -> 0x80000100 -> after the next redirect to 0x80000010, pre_pc = 0x80000100 and the following request address is 0x80000100.
